// File: rtl/rf_op_sequencer.sv
// Three-cycle (IDLE/EXEC/WB) two-operand operation sequencer driving a register file.
// Optional condition flags output compiled in with RF_OP_SEQUENCER_FLAGS_EN.
module rf_op_sequencer #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [3:0]       op_rdest,
    input  logic [3:0]       op_rsrc,
    input  logic [7:0]       op_imm,
    output logic [3:0]       raddrA,
    output logic [3:0]       raddrB,
    input  logic [WIDTH-1:0] rdataA,
    input  logic [WIDTH-1:0] rdataB,
    output logic [WIDTH-1:0] wdata,
    output logic [NREGS-1:0] regEnable,
    output logic             done,
`ifdef RF_OP_SEQUENCER_FLAGS_EN
    output logic [4:0]       flags,
`endif
    output logic [1:0]       state_dbg
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_MOV  = 3'b101;
    localparam logic [2:0] OP_MOVI = 3'b110;
    localparam logic [2:0] OP_CMP  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    // Handshake: a request transfers on a rising edge where op_valid && op_ready;
    // op_ready is high only in IDLE and out of reset, and requests are never queued.
    state_t state, state_nxt;

    logic [2:0]       code_q;
    logic [3:0]       rdest_q;
    logic [3:0]       rsrc_q;
    logic [7:0]       imm_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] alu_res;
    logic             accept;

    assign accept = op_valid && op_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        op_ready  = 1'b0;
        done      = 1'b0;
        regEnable = '0;
        case (state)
            S_IDLE: begin
                op_ready = reset;
                if (op_valid && reset) state_nxt = S_EXEC;
            end
            S_EXEC: state_nxt = S_WB;
            S_WB: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
                if (code_q != OP_CMP) regEnable = NREGS'(1) << rdest_q;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign raddrA    = rdest_q;
    assign raddrB    = rsrc_q;
    assign wdata     = result_q;
    assign state_dbg = state;

    always_comb begin
        alu_res = result_q;
        case (code_q)
            OP_ADD:  alu_res = rdataA + rdataB;
            OP_SUB:  alu_res = rdataA - rdataB;
            OP_AND:  alu_res = rdataA & rdataB;
            OP_OR:   alu_res = rdataA | rdataB;
            OP_XOR:  alu_res = rdataA ^ rdataB;
            OP_MOV:  alu_res = rdataB;
            OP_MOVI: alu_res = {{(WIDTH-8){1'b0}}, imm_q};
            default: alu_res = result_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_q   <= '0;
            rdest_q  <= '0;
            rsrc_q   <= '0;
            imm_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                code_q  <= op_code;
                rdest_q <= op_rdest;
                rsrc_q  <= op_rsrc;
                imm_q   <= op_imm;
            end
            // CMP keeps the previous result since it never writes back.
            if (state == S_EXEC) result_q <= alu_res;
        end
    end

`ifdef RF_OP_SEQUENCER_FLAGS_EN
    // flags = {C, L, F, Z, N}; C on SUB is the borrow (A < B unsigned).
    logic [WIDTH:0] add_full;
    logic [WIDTH:0] sub_full;
    logic           a_msb, b_msb;

    assign add_full = {1'b0, rdataA} + {1'b0, rdataB};
    assign sub_full = {1'b0, rdataA} - {1'b0, rdataB};
    assign a_msb    = rdataA[WIDTH-1];
    assign b_msb    = rdataB[WIDTH-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= '0;
        end else if (state == S_EXEC) begin
            case (code_q)
                OP_ADD: begin
                    flags[4] <= add_full[WIDTH];
                    flags[2] <= (a_msb == b_msb) && (add_full[WIDTH-1] != a_msb);
                end
                OP_SUB: begin
                    flags[4] <= sub_full[WIDTH];
                    flags[2] <= (a_msb != b_msb) && (sub_full[WIDTH-1] != a_msb);
                end
                OP_CMP: begin
                    flags[1] <= (rdataA == rdataB);
                    flags[3] <= (rdataA < rdataB);
                    flags[0] <= ($signed(rdataA) < $signed(rdataB));
                end
                default: flags <= flags;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Directed bench for rf_op_sequencer with a behavioural 16x16 register file.
// Flag checks are included when RF_OP_SEQUENCER_FLAGS_EN is defined.
module tb_rf_op_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [2:0]  op_code = '0;
    logic [3:0]  op_rdest = '0;
    logic [3:0]  op_rsrc = '0;
    logic [7:0]  op_imm = '0;
    logic [3:0]  raddrA, raddrB;
    logic [15:0] rdataA, rdataB;
    logic [15:0] wdata;
    logic [15:0] regEnable;
    logic        done;
    logic [1:0]  state_dbg;
`ifdef RF_OP_SEQUENCER_FLAGS_EN
    logic [4:0]  flags;
`endif

    int checks = 0;
    int failures = 0;

    logic [15:0] rf [16];
    logic        rf_clr = 1'b1;
    logic        pre_we = 1'b0;
    logic [3:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    rf_op_sequencer #(.WIDTH(16), .NREGS(16)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_rdest(op_rdest), .op_rsrc(op_rsrc), .op_imm(op_imm),
        .raddrA(raddrA), .raddrB(raddrB), .rdataA(rdataA), .rdataB(rdataB),
        .wdata(wdata), .regEnable(regEnable), .done(done),
`ifdef RF_OP_SEQUENCER_FLAGS_EN
        .flags(flags),
`endif
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    assign rdataA = rf[raddrA];
    assign rdataB = rf[raddrB];

    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (rf_clr) rf[i] <= '0;
            else if (regEnable[i]) rf[i] <= wdata;
        end
        if (pre_we) rf[pre_addr] <= pre_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [2:0] code, input logic [3:0] rd,
                         input logic [3:0] rs, input logic [7:0] imm,
                         input logic [15:0] exp_wdata, input logic [15:0] exp_en);
        @(negedge clk);
        op_valid = 1'b1; op_code = code; op_rdest = rd; op_rsrc = rs; op_imm = imm;
        @(posedge clk); #1;
        op_valid = 1'b0;
        check({tag, "_exec_ready"}, {31'd0, op_ready}, 32'd0);
        check({tag, "_exec_en"}, {16'd0, regEnable}, 32'd0);
        check({tag, "_exec_raddrA"}, {28'd0, raddrA}, {28'd0, rd});
        check({tag, "_exec_raddrB"}, {28'd0, raddrB}, {28'd0, rs});
        @(posedge clk); #1;
        check({tag, "_wb_done"}, {31'd0, done}, 32'd1);
        check({tag, "_wb_ready"}, {31'd0, op_ready}, 32'd0);
        check({tag, "_wb_en"}, {16'd0, regEnable}, {16'd0, exp_en});
        if (exp_en != 16'd0) check({tag, "_wb_wdata"}, {16'd0, wdata}, {16'd0, exp_wdata});
        @(posedge clk); #1;
        check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
        check({tag, "_idle_ready"}, {31'd0, op_ready}, 32'd1);
    endtask

    initial begin
        int accepts;
        int rd_t [6];
        logic [5:0] ready_pat;
        rd_t = '{1, 2, 6, 7, 10, 11};
        ready_pat = 6'b100100;

        // Reset held
        #1;
        check("rst_held_ready", {31'd0, op_ready}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_ready", {31'd0, op_ready}, 32'd1);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        check("rst_raddrA", {28'd0, raddrA}, 32'd0);
        check("rst_raddrB", {28'd0, raddrB}, 32'd0);
        check("rst_wdata", {16'd0, wdata}, 32'd0);
        check("rst_en", {16'd0, regEnable}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
`ifdef RF_OP_SEQUENCER_FLAGS_EN
        check("rst_flags", {27'd0, flags}, 32'd0);
`endif
        @(posedge clk); #1;
        rf_clr = 1'b0;

        // MOVI r3,0xCD
        do_op("movi", 3'b110, 4'd3, 4'd0, 8'hCD, 16'h00CD, 16'h0008);
        check("movi_r3", {16'd0, rf[3]}, 32'h0000_00CD);

        // ADD / SUB
        preload(4'd3, 16'hABCD);
        preload(4'd5, 16'h1234);
        do_op("add", 3'b000, 4'd3, 4'd5, 8'h00, 16'hBE01, 16'h0008);
        check("add_r3", {16'd0, rf[3]}, 32'h0000_BE01);
        preload(4'd3, 16'hABCD);
        do_op("sub", 3'b001, 4'd5, 4'd3, 8'h00, 16'h6667, 16'h0020);
        check("sub_r5", {16'd0, rf[5]}, 32'h0000_6667);

        // Logic ops and MOV, including rdest == rsrc
        preload(4'd5, 16'h1234);
        do_op("and", 3'b010, 4'd3, 4'd5, 8'h00, 16'h0204, 16'h0008);
        preload(4'd3, 16'hABCD);
        do_op("or", 3'b011, 4'd3, 4'd5, 8'h00, 16'hBBFD, 16'h0008);
        preload(4'd3, 16'hABCD);
        do_op("xor", 3'b100, 4'd3, 4'd5, 8'h00, 16'hB9F9, 16'h0008);
        do_op("mov", 3'b101, 4'd12, 4'd5, 8'h00, 16'h1234, 16'h1000);
        do_op("xor_self", 3'b100, 4'd5, 4'd5, 8'h00, 16'h0000, 16'h0020);
        preload(4'd5, 16'h1234);
        preload(4'd3, 16'hABCD);

        // CMP: no write-back
        do_op("cmp", 3'b111, 4'd3, 4'd5, 8'h00, 16'h0000, 16'h0000);
        check("cmp_r3", {16'd0, rf[3]}, 32'h0000_ABCD);
        check("cmp_r5", {16'd0, rf[5]}, 32'h0000_1234);
`ifdef RF_OP_SEQUENCER_FLAGS_EN
        check("cmp_z", {31'd0, flags[1]}, 32'd0);
        check("cmp_l", {31'd0, flags[3]}, 32'd0);
        check("cmp_n", {31'd0, flags[0]}, 32'd1);
`endif

        // ADD wrap and overflow
        preload(4'd8, 16'hFFFF);
        preload(4'd9, 16'h0001);
        do_op("add_wrap", 3'b000, 4'd8, 4'd9, 8'h00, 16'h0000, 16'h0100);
`ifdef RF_OP_SEQUENCER_FLAGS_EN
        check("wrap_c", {31'd0, flags[4]}, 32'd1);
        check("wrap_f", {31'd0, flags[2]}, 32'd0);
`endif
        preload(4'd8, 16'h7FFF);
        do_op("add_ovf", 3'b000, 4'd8, 4'd9, 8'h00, 16'h8000, 16'h0100);
`ifdef RF_OP_SEQUENCER_FLAGS_EN
        check("ovf_c", {31'd0, flags[4]}, 32'd0);
        check("ovf_f", {31'd0, flags[2]}, 32'd1);
`endif

        // op_valid held for 6 cycles: only cycles 0 and 3 accept
        accepts = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            op_valid = 1'b1;
            op_code  = 3'b110;
            op_rdest = 4'(rd_t[k]);
            op_rsrc  = 4'd0;
            op_imm   = {4'(rd_t[k]), 4'(rd_t[k])};
            #1;
            check($sformatf("burst_ready%0d", k), {31'd0, op_ready}, {31'd0, ready_pat[5-k]});
            if (op_valid && op_ready) accepts++;
        end
        @(negedge clk);
        op_valid = 1'b0;
        check("burst_accepts", accepts, 32'd2);
        check("burst_r1", {16'd0, rf[1]}, 32'h0000_0011);
        check("burst_r7", {16'd0, rf[7]}, 32'h0000_0077);
        check("burst_r2", {16'd0, rf[2]}, 32'd0);
        check("burst_r10", {16'd0, rf[10]}, 32'd0);

        // Reset during WB aborts the write
        preload(4'd4, 16'h1111);
        @(negedge clk);
        op_valid = 1'b1; op_code = 3'b110; op_rdest = 4'd4; op_rsrc = 4'd0; op_imm = 8'h55;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_wb_done", {31'd0, done}, 32'd1);
        check("abort_wb_en", {16'd0, regEnable}, 32'h0000_0010);
        #2;
        reset = 1'b0;
        #1;
        check("abort_en", {16'd0, regEnable}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_ready_held", {31'd0, op_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_ready", {31'd0, op_ready}, 32'd1);
        check("abort_raddrA", {28'd0, raddrA}, 32'd0);
        check("abort_state", {30'd0, state_dbg}, 32'd0);
        @(posedge clk); #1;
        check("abort_r4", {16'd0, rf[4]}, 32'h0000_1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
